output_vc_credit_tracker: RTL and testbench
===========================================

// Module: output_vc_credit_tracker
// PURPOSE
//  Upstream (transmit) end of the credit-based link whose receive side is the per-VC input fifo.
//  Tracks the free slots of each downstream VC buffer, gates flit sends and registers the accepted flit onto the link.
//  Runs a per-VC IDLE/ACTIVE/DRAINING state machine, so a downstream VC is reallocated only once fully empty.
//  One instance sits at each router output port, after the switch traversal stage.
// PARAMETERS
//  NUM_VCS       4                      number of virtual channels on the link
//  BUFFER_DEPTH  8                      downstream fifo depth per VC; initial/maximum credit count
//  DATA_WIDTH    `FLIT_DATA_WIDTH       flit payload width
//  CREDIT_WIDTH  $clog2(BUFFER_DEPTH)+1 credit counter width; must hold BUFFER_DEPTH
//  VC_ID_WIDTH   $clog2(NUM_VCS)        VC index width
// PORTS
//  clk               in   1             clock; all state on posedge
//  reset             in   1             synchronous, active-high reset
//  send_valid        in   1             switch presents a flit this cycle
//  send_vc           in   VC_ID_WIDTH   target downstream VC
//  send_head         in   1             flit is a head flit
//  send_tail         in   1             flit is a tail flit (head+tail = single-flit packet)
//  send_data         in   DATA_WIDTH    flit payload
//  send_accept       out  1             comb: flit accepted this cycle
//  send_err          out  1             registered 1-cycle pulse: illegal send dropped
//  credit_valid      in   1             downstream returns one credit (one fifo pop)
//  credit_vc         in   VC_ID_WIDTH   VC of returned credit
//  link_valid        out  1             registered: flit on link
//  link_vc           out  VC_ID_WIDTH   registered VC of link flit
//  link_data         out  DATA_WIDTH    registered link payload
//  credit_avail      out  NUM_VCS       bit v = credit count[v] > 0
//  vc_idle           out  NUM_VCS       bit v = VC v in IDLE (free for VC allocation)
//  credit_ovf_err    out  1             sticky: credit returned to a VC already at BUFFER_DEPTH
// BEHAVIOUR
//  Reset: all counts = BUFFER_DEPTH, all VCs IDLE; link_valid, link_vc, link_data, send_err, credit_ovf_err = 0;
//   credit_avail = all ones, vc_idle = all ones. Reset mid-packet discards all state; no flit is emitted on the following cycle.
//  Accept rule, send_accept = send_valid && count[send_vc] > 0 && legal, where
//   legal = (send_head && state==IDLE) || (!send_head && state==ACTIVE).
//  Illegal send (no credit or wrong state): flit dropped, state/count unchanged, send_err pulses next cycle.
//  Latency: accepted flit appears on link_* exactly 1 cycle later; link_valid = 0 on cycles with no accept.
//  Count[v]: -1 on accept to v; +1 on credit_valid to v; both in the same cycle leave it unchanged.
//   Credit to a VC at BUFFER_DEPTH with no simultaneous send: count saturates, credit_ovf_err set until reset.
//  VC FSM, per VC (vc_state_t):
//   IDLE     -head accepted, !tail-> ACTIVE;  head+tail accepted -> DRAINING
//   ACTIVE   -tail accepted-> DRAINING;  head to ACTIVE VC is illegal (send_err)
//   DRAINING -count (after this cycle's update) == BUFFER_DEPTH-> IDLE; all sends to the VC are illegal
//   DRAINING with count already full on tail cycle -> IDLE on next cycle (no zero-cycle skip)
//  credit_avail and vc_idle are decoded from registered state: updates are visible the cycle after the event.
//  Credits for different VCs and sends to other VCs are independent in the same cycle.
// STRUCTURE
//  router_pkg: vc_state_t enum {VC_IDLE, VC_ACTIVE, VC_DRAINING}; flit-type constants; VC_ID_WIDTH helper.
//  Sub-module: vc_credit_counter (one per VC, generate loop): inc/dec inputs, saturating count, ovf flag,
//   full/nonzero outputs. Top level holds the FSM array, the accept decode and the link output register.
// TESTING
//  After reset: credit_avail=4'b1111, vc_idle=4'b1111, link_valid=0, counts=8.
//  Head(vc1), 6 body, tail: 8 accepts, link_* follows 1 cycle later; vc1 in DRAINING with count 0;
//   9th flit -> send_err=1, no link_valid.
//  With vc1 DRAINING at count 0: return 8 credits -> vc1 IDLE the cycle after the 8th credit;
//   a new head is accepted after that.
//  Same-cycle send and credit on vc2 with count 3: count stays 3; different VCs both update.
//  Body flit to an IDLE VC, or head flit to an ACTIVE VC -> send_err pulse, state/count unchanged.
//  Credit to a VC with count 8 -> credit_ovf_err=1 and held; count stays 8.
//  Reset asserted mid-packet on vc0 -> next cycle all VCs IDLE, counts 8, link_valid 0.

Source files
------------

// File: rtl/output_vc_credit_tracker_pkg.sv
// Shared types and constants for the output-port VC credit tracker.
// Holds the per-VC allocation states and the {head,tail} flit-type encodings.
package output_vc_credit_tracker_pkg;

  typedef enum logic [1:0] {
    VC_IDLE     = 2'd0,
    VC_ACTIVE   = 2'd1,
    VC_DRAINING = 2'd2
  } vc_state_t;

  // Flit type as {head, tail}.
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  function automatic int vc_id_width(input int num_vcs);
    return (num_vcs > 1) ? $clog2(num_vcs) : 1;
  endfunction

endpackage

// File: rtl/output_vc_credit_tracker_counter.sv
// Saturating per-VC credit counter. It starts full and counts free downstream slots.
// "full" reports the count after this cycle's update, so a drain can finish on the same edge.
module vc_credit_counter #(
  parameter int BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full,
  output logic ovf
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_COUNT = CREDIT_WIDTH'(BUFFER_DEPTH);

  logic [CREDIT_WIDTH-1:0] count_r;
  logic [CREDIT_WIDTH-1:0] count_next_s;
  logic                    ovf_r;
  logic                    ovf_hit_s;

  // Next count: a send and a credit in the same cycle cancel out.
  always_comb begin
    count_next_s = count_r;
    ovf_hit_s    = 1'b0;
    if (inc && !dec) begin
      if (count_r == MAX_COUNT) begin
        ovf_hit_s    = 1'b1;
        count_next_s = count_r;
      end else begin
        count_next_s = count_r + CREDIT_WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (count_r != {CREDIT_WIDTH{1'b0}}) begin
        count_next_s = count_r - CREDIT_WIDTH'(1);
      end else begin
        count_next_s = count_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= MAX_COUNT;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ovf_r   <= ovf_r | ovf_hit_s;
    end
  end

  assign nonzero = (count_r != {CREDIT_WIDTH{1'b0}});
  assign full    = (count_next_s == MAX_COUNT);
  assign ovf     = ovf_r;

endmodule

// File: rtl/output_vc_credit_tracker.sv
// Transmit side of a credit-based link. It gates flit sends on downstream credit and the per-VC state.
// Accepted flits are registered onto the link. A VC frees up for reallocation only once the downstream VC has drained.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module output_vc_credit_tracker
  import output_vc_credit_tracker_pkg::*;
#(
  parameter int NUM_VCS      = 4,
  parameter int BUFFER_DEPTH = 8,
  parameter int DATA_WIDTH   = `FLIT_DATA_WIDTH,
  parameter int CREDIT_WIDTH = $clog2(BUFFER_DEPTH) + 1,
  parameter int VC_ID_WIDTH  = vc_id_width(NUM_VCS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send_valid,
  input  logic [VC_ID_WIDTH-1:0] send_vc,
  input  logic                   send_head,
  input  logic                   send_tail,
  input  logic [DATA_WIDTH-1:0]  send_data,
  output logic                   send_accept,
  output logic                   send_err,
  input  logic                   credit_valid,
  input  logic [VC_ID_WIDTH-1:0] credit_vc,
  output logic                   link_valid,
  output logic [VC_ID_WIDTH-1:0] link_vc,
  output logic [DATA_WIDTH-1:0]  link_data,
  output logic [NUM_VCS-1:0]     credit_avail,
  output logic [NUM_VCS-1:0]     vc_idle,
  output logic                   credit_ovf_err
);

  vc_state_t                state_r      [NUM_VCS];
  vc_state_t                state_next_s [NUM_VCS];
  vc_state_t                sel_state_s;
  logic [1:0]               flit_type_s;
  logic                     legal_s;
  logic                     accept_s;
  logic [NUM_VCS-1:0]       inc_s;
  logic [NUM_VCS-1:0]       dec_s;
  logic [NUM_VCS-1:0]       nonzero_s;
  logic [NUM_VCS-1:0]       full_next_s;
  logic [NUM_VCS-1:0]       ovf_s;
  logic [NUM_VCS-1:0]       vc_idle_s;
  logic                     link_valid_r;
  logic [VC_ID_WIDTH-1:0]   link_vc_r;
  logic [DATA_WIDTH-1:0]    link_data_r;
  logic                     send_err_r;

  assign flit_type_s = {send_head, send_tail};

  // Accept decode: a head opens an IDLE VC, and a body or tail continues an ACTIVE one.
  always_comb begin
    sel_state_s = state_r[send_vc];
    legal_s     = 1'b0;
    case (sel_state_s)
      VC_IDLE:     legal_s = send_head;
      VC_ACTIVE:   legal_s = !send_head;
      VC_DRAINING: legal_s = 1'b0;
      default:     legal_s = 1'b0;
    endcase
    accept_s = send_valid && nonzero_s[send_vc] && legal_s;
  end

  // Per-VC credit increment and decrement strobes.
  always_comb begin
    inc_s = {NUM_VCS{1'b0}};
    dec_s = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      if (credit_valid && (credit_vc == VC_ID_WIDTH'(v))) begin
        inc_s[v] = 1'b1;
      end else begin
        inc_s[v] = 1'b0;
      end
      if (accept_s && (send_vc == VC_ID_WIDTH'(v))) begin
        dec_s[v] = 1'b1;
      end else begin
        dec_s[v] = 1'b0;
      end
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    vc_credit_counter #(
      .BUFFER_DEPTH (BUFFER_DEPTH),
      .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc_s[v]),
      .dec     (dec_s[v]),
      .nonzero (nonzero_s[v]),
      .full    (full_next_s[v]),
      .ovf     (ovf_s[v])
    );
  end

  // VC FSM next state. DRAINING waits for the post-update count to reach full again.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      state_next_s[v] = state_r[v];
      case (state_r[v])
        VC_IDLE: begin
          if (dec_s[v] && (flit_type_s == FLIT_SINGLE)) begin
            state_next_s[v] = VC_DRAINING;
          end else if (dec_s[v]) begin
            state_next_s[v] = VC_ACTIVE;
          end else begin
            state_next_s[v] = VC_IDLE;
          end
        end
        VC_ACTIVE: begin
          if (dec_s[v] && (flit_type_s == FLIT_TAIL)) begin
            state_next_s[v] = VC_DRAINING;
          end else begin
            state_next_s[v] = VC_ACTIVE;
          end
        end
        VC_DRAINING: begin
          if (full_next_s[v]) begin
            state_next_s[v] = VC_IDLE;
          end else begin
            state_next_s[v] = VC_DRAINING;
          end
        end
        default: state_next_s[v] = VC_IDLE;
      endcase
    end
  end

  // VC FSM state register.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (reset) begin
        state_r[v] <= VC_IDLE;
      end else begin
        state_r[v] <= state_next_s[v];
      end
    end
  end

  // Link output and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_r <= 1'b0;
      link_vc_r    <= {VC_ID_WIDTH{1'b0}};
      link_data_r  <= {DATA_WIDTH{1'b0}};
      send_err_r   <= 1'b0;
    end else begin
      link_valid_r <= accept_s;
      send_err_r   <= send_valid && !accept_s;
      if (accept_s) begin
        link_vc_r   <= send_vc;
        link_data_r <= send_data;
      end
    end
  end

  // VC-allocation view of the registered states.
  always_comb begin
    vc_idle_s = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      vc_idle_s[v] = (state_r[v] == VC_IDLE);
    end
  end

  assign send_accept    = accept_s;
  assign send_err       = send_err_r;
  assign link_valid     = link_valid_r;
  assign link_vc        = link_vc_r;
  assign link_data      = link_data_r;
  assign credit_avail   = nonzero_s;
  assign vc_idle        = vc_idle_s;
  assign credit_ovf_err = |ovf_s;

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// Scoreboard bench: the stimulus process queues the expected link flits and errors, and a negedge monitor checks them.
// The reference model tracks free slots and packet phase per VC as plain integers.
module tb_output_vc_credit_tracker;

  localparam int NV    = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          send_valid, send_head, send_tail, credit_valid;
  logic [1:0]    send_vc, credit_vc;
  logic [DW-1:0] send_data;
  logic          send_accept, send_err, link_valid, credit_ovf_err;
  logic [1:0]    link_vc;
  logic [DW-1:0] link_data;
  logic [NV-1:0] credit_avail, vc_idle;

  output_vc_credit_tracker #(
    .NUM_VCS(NV), .BUFFER_DEPTH(DEPTH), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .send_valid(send_valid), .send_vc(send_vc), .send_head(send_head),
    .send_tail(send_tail), .send_data(send_data), .send_accept(send_accept),
    .send_err(send_err), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .link_valid(link_valid), .link_vc(link_vc), .link_data(link_data),
    .credit_avail(credit_avail), .vc_idle(vc_idle), .credit_ovf_err(credit_ovf_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: free slots per VC; phase 0 = free, 1 = in packet, 2 = waiting for all credits back.
  int m_cred [NV];
  int m_mode [NV];
  bit m_ovf;

  logic [DW+1:0] exp_link[$];
  bit            exp_err[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_cred[v] = DEPTH;
      m_mode[v] = 0;
    end
    m_ovf = 1'b0;
  endtask

  task automatic check_state();
    logic [NV-1:0] ea, ei;
    for (int v = 0; v < NV; v++) begin
      ea[v] = (m_cred[v] > 0);
      ei[v] = (m_mode[v] == 0);
    end
    chk("credit_avail", 64'(credit_avail), 64'(ea));
    chk("vc_idle", 64'(vc_idle), 64'(ei));
    chk("credit_ovf_err", 64'(credit_ovf_err), 64'(m_ovf));
  endtask

  task automatic step(input bit sv, input logic [1:0] vc, input bit hd, input bit tl,
                      input logic [DW-1:0] d, input bit cv, input logic [1:0] cvc);
    bit acc;
    int c;
    @(posedge clk); #1;
    check_state();
    send_valid = sv; send_vc = vc; send_head = hd; send_tail = tl; send_data = d;
    credit_valid = cv; credit_vc = cvc;
    #1;
    acc = sv && (m_cred[vc] > 0) && (hd ? (m_mode[vc] == 0) : (m_mode[vc] == 1));
    chk("send_accept", 64'(send_accept), 64'(acc));
    if (acc) exp_link.push_back({vc, d});
    else if (sv) exp_err.push_back(1'b1);
    for (int v = 0; v < NV; v++) begin
      c = m_cred[v];
      if (acc && vc == v) c = c - 1;
      if (cv && cvc == v) begin
        if (m_cred[v] == DEPTH && !(acc && vc == v)) m_ovf = 1'b1;
        else c = c + 1;
      end
      if (acc && vc == v) begin
        if (tl) m_mode[v] = 2;
        else m_mode[v] = 1;
      end else if (m_mode[v] == 2 && c == DEPTH) begin
        m_mode[v] = 0;
      end
      m_cred[v] = c;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic do_reset(input bit mid_pkt);
    @(posedge clk); #1;
    check_state();
    reset = 1'b1;
    send_valid = mid_pkt; send_vc = 2'd0; send_head = 1'b0; send_tail = 1'b0;
    send_data = $urandom; credit_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    send_valid = 1'b0;
    model_reset();
    chk("reset_link_valid", 64'(link_valid), 64'(0));
    chk("reset_send_err", 64'(send_err), 64'(0));
    check_state();
  endtask

  // Monitor: match each registered link flit or error pulse against the scoreboard.
  always @(negedge clk) begin
    if (link_valid === 1'b1) begin
      if (exp_link.size() == 0) begin
        checks++; failures++;
        $display("FAIL link_unexpected actual=vc%0d/%0h required=none", link_vc, link_data);
      end else begin
        logic [DW+1:0] e;
        e = exp_link.pop_front();
        chk("link_vc", 64'(link_vc), 64'(e[DW+1:DW]));
        chk("link_data", 64'(link_data), 64'(e[DW-1:0]));
      end
    end
    if (send_err === 1'b1) begin
      if (exp_err.size() == 0) begin
        checks++; failures++;
        $display("FAIL send_err_unexpected actual=1 required=0");
      end else begin
        void'(exp_err.pop_front());
      end
    end
  end

  initial begin
    bit sv, hd, tl, cv;
    logic [1:0] vc, cvc;
    reset = 1'b1; send_valid = 1'b0; send_vc = 2'd0; send_head = 1'b0; send_tail = 1'b0;
    send_data = '0; credit_valid = 1'b0; credit_vc = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("init_link_valid", 64'(link_valid), 64'(0));
    chk("init_send_err", 64'(send_err), 64'(0));
    chk("init_credit_avail", 64'(credit_avail), 64'(4'b1111));
    chk("init_vc_idle", 64'(vc_idle), 64'(4'b1111));
    chk("init_ovf", 64'(credit_ovf_err), 64'(0));
    reset = 1'b0;

    // Full packet on vc1 consumes every credit, then sends with no credit are refused.
    step(1'b1, 2'd1, 1'b1, 1'b0, $urandom, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd1, 1'b0, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd1, 1'b0, 1'b1, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd1, 1'b0, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd1, 1'b1, 1'b0, $urandom, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 2'd1);
    step(1'b1, 2'd1, 1'b1, 1'b1, $urandom, 1'b0, 2'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 2'd1);
    idle(2);

    // vc2 down to 3 credits, then a send and a credit in the same cycle; vc0 opened meanwhile.
    step(1'b1, 2'd2, 1'b1, 1'b0, $urandom, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 1'b0, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd2, 1'b0, 1'b0, $urandom, 1'b1, 2'd2);
    step(1'b1, 2'd0, 1'b1, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd2, 1'b0, 1'b0, $urandom, 1'b1, 2'd0);

    // Wrong-phase sends, then overflow on a full VC.
    step(1'b1, 2'd3, 1'b0, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b1, 2'd2, 1'b1, 1'b0, $urandom, 1'b0, 2'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, '0, 1'b1, 2'd3);
    idle(3);

    // Reset in the middle of the vc0 packet.
    step(1'b1, 2'd0, 1'b0, 1'b0, $urandom, 1'b0, 2'd0);
    do_reset(1'b1);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      vc  = 2'($urandom_range(0, 3));
      sv  = ($urandom_range(0, 3) != 0);
      hd  = (m_mode[vc] == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      tl  = ($urandom_range(0, 2) == 0);
      cvc = 2'($urandom_range(0, 3));
      cv  = ($urandom_range(0, 1) == 1);
      if (m_cred[cvc] == DEPTH && $urandom_range(0, 99) != 0) cv = 1'b0;
      step(sv, vc, hd, tl, $urandom, cv, cvc);
    end
    idle(3);
    chk("link_queue_empty", 64'(exp_link.size()), 64'(0));
    chk("err_queue_empty", 64'(exp_err.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
